// File: rtl/qspi_rom_fetch_ctrl_if.sv
// CPU-side request bus and shared QSPI pin group for the cartridge ROM fetch controller.
interface qspi_rom_fetch_ctrl_if;
    logic        req;
    logic [11:0] addr;
    logic        flush;
    logic        ready;
    logic [7:0]  data;
    logic        stall;
    logic        spi_clk;
    logic        spi_select;
    logic [3:0]  spi_out;
    logic [3:0]  spi_oe;
    logic [3:0]  spi_in;

    modport master (
        output req, addr, flush, spi_in,
        input  ready, data, stall, spi_clk, spi_select, spi_out, spi_oe
    );

    modport slave (
        input  req, addr, flush, spi_in,
        output ready, data, stall, spi_clk, spi_select, spi_out, spi_oe
    );
endinterface

// File: rtl/qspi_rom_fetch_ctrl.sv
// Single-byte QSPI flash read sequencer for 6502 cartridge ROM space with a one-entry byte cache.
// Every pin output is registered; stall is the only combinational output.
module qspi_rom_fetch_ctrl #(
    parameter logic [23:0] BASE_ADDR    = 24'h000000,
    parameter logic [7:0]  READ_CMD     = 8'hEB,
    parameter int unsigned DUMMY_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    qspi_rom_fetch_ctrl_if.slave   bus
);

    localparam int unsigned NIB_TOTAL = 10 + DUMMY_CYCLES;
    localparam logic [4:0]  K_DATA    = 5'(8 + DUMMY_CYCLES);
    localparam logic [4:0]  K_LAST    = 5'(NIB_TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
    } state_t;

    state_t      r_state, w_state;
    logic [4:0]  r_k, w_k;
    logic        r_ph, w_ph;
    logic        r_sel, w_sel;
    logic        r_sclk, w_sclk;
    logic [3:0]  r_out, w_out;
    logic [3:0]  r_oe, w_oe;
    logic        r_ready, w_ready;
    logic [7:0]  r_data, w_data;
    logic [3:0]  r_hi, w_hi;
    logic [23:0] r_faddr, w_faddr;
    logic [11:0] r_lat_tag, w_lat_tag;
    logic [11:0] r_tag, w_tag;
    logic [7:0]  r_cache, w_cache;
    logic        r_valid, w_valid;
    logic        r_flush_seen, w_flush_seen;
    logic        w_hit;

    // Global nibble index k selects the phase: 0-1 command, 2-7 address, then dummy, then data.
    function automatic state_t state_of(input logic [4:0] k);
        if (k < 5'd2)
            return S_CMD;
        else if (k < 5'd8)
            return S_ADDR;
        else if (k < K_DATA)
            return S_DUMMY;
        return S_DATA;
    endfunction

    function automatic logic [3:0] nib_of(input logic [4:0] k, input logic [23:0] fa);
        logic [2:0] j;
        j = 3'd7 - k[2:0];
        if (k == 5'd0)
            return READ_CMD[7:4];
        else if (k == 5'd1)
            return READ_CMD[3:0];
        return fa[{j, 2'b00} +: 4];
    endfunction

    assign w_hit = r_valid & ~bus.flush & (r_tag == bus.addr);

    always_comb begin
        w_state      = r_state;
        w_k          = r_k;
        w_ph         = r_ph;
        w_sel        = r_sel;
        w_sclk       = r_sclk;
        w_out        = r_out;
        w_oe         = r_oe;
        w_ready      = 1'b0;
        w_data       = r_data;
        w_hi         = r_hi;
        w_faddr      = r_faddr;
        w_lat_tag    = r_lat_tag;
        w_tag        = r_tag;
        w_cache      = r_cache;
        w_valid      = r_valid;
        w_flush_seen = r_flush_seen;

        if (bus.flush) begin
            w_valid      = 1'b0;
            w_flush_seen = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_sel  = 1'b1;
                w_sclk = 1'b0;
                w_out  = '0;
                w_oe   = '0;
                if (bus.req) begin
                    if (w_hit) begin
                        w_state = S_DONE;
                        w_ready = 1'b1;
                        w_data  = r_cache;
                    end else begin
                        w_state      = S_CMD;
                        w_faddr      = BASE_ADDR + {12'h000, bus.addr};
                        w_lat_tag    = bus.addr;
                        w_k          = '0;
                        w_ph         = 1'b0;
                        w_sel        = 1'b0;
                        w_oe         = '1;
                        w_out        = READ_CMD[7:4];
                        w_flush_seen = bus.flush;
                    end
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (!r_ph) begin
                    w_ph   = 1'b1;
                    w_sclk = 1'b1;
                end else begin
                    w_ph   = 1'b0;
                    w_sclk = 1'b0;
                    if (r_k == K_DATA)
                        w_hi = bus.spi_in;
                    if (r_k == K_LAST) begin
                        w_state = S_DONE;
                        w_sel   = 1'b1;
                        w_oe    = '0;
                        w_out   = '0;
                        w_ready = 1'b1;
                        w_data  = {r_hi, bus.spi_in};
                        // A flush anywhere in the fetch, including this edge, keeps the byte uncached.
                        if (!r_flush_seen && !bus.flush) begin
                            w_valid = 1'b1;
                            w_tag   = r_lat_tag;
                            w_cache = {r_hi, bus.spi_in};
                        end
                    end else begin
                        w_k     = r_k + 5'd1;
                        w_state = state_of(w_k);
                        if (w_k < 5'd8) begin
                            w_oe  = '1;
                            w_out = nib_of(w_k, r_faddr);
                        end else begin
                            w_oe  = '0;
                            w_out = '0;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_ph         <= 1'b0;
            r_sel        <= 1'b1;
            r_sclk       <= 1'b0;
            r_out        <= '0;
            r_oe         <= '0;
            r_ready      <= 1'b0;
            r_data       <= '0;
            r_hi         <= '0;
            r_faddr      <= '0;
            r_lat_tag    <= '0;
            r_tag        <= '0;
            r_cache      <= '0;
            r_valid      <= 1'b0;
            r_flush_seen <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_k          <= w_k;
            r_ph         <= w_ph;
            r_sel        <= w_sel;
            r_sclk       <= w_sclk;
            r_out        <= w_out;
            r_oe         <= w_oe;
            r_ready      <= w_ready;
            r_data       <= w_data;
            r_hi         <= w_hi;
            r_faddr      <= w_faddr;
            r_lat_tag    <= w_lat_tag;
            r_tag        <= w_tag;
            r_cache      <= w_cache;
            r_valid      <= w_valid;
            r_flush_seen <= w_flush_seen;
        end
    end

    assign bus.stall      = (bus.req & ~w_hit & (r_state == S_IDLE)) |
                            (r_state == S_CMD) | (r_state == S_ADDR) |
                            (r_state == S_DUMMY) | (r_state == S_DATA);
    assign bus.ready      = r_ready;
    assign bus.data       = r_data;
    assign bus.spi_clk    = r_sclk;
    assign bus.spi_select = r_sel;
    assign bus.spi_out    = r_out;
    assign bus.spi_oe     = r_oe;

endmodule

// File: tb/tb_qspi_rom_fetch_ctrl.sv
// Bench for qspi_rom_fetch_ctrl: two instances (zero and wrapping flash base) with flash emulators,
// a transaction-level expectation model, directed scenarios and randomized request traffic.
module tb_qspi_rom_fetch_ctrl;

    localparam int unsigned DUM = 2;
    localparam int unsigned T   = 10 + DUM;
    localparam logic [7:0]  CMD = 8'hEB;

    typedef struct packed {
        logic [1:0] kind;   // 0 idle, 1 bus fetch cycle, 2 ready cycle
        logic       sel;
        logic       sclk;
        logic [3:0] oe;
        logic [3:0] out;
        logic       ready;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [11:0] addr;
    logic        flush;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  emu_cmd[2];
    logic [23:0] emu_addr[2];
    int          emu_ntx[2];

    always #5 clk = ~clk;

    qspi_rom_fetch_ctrl_if bus[2] ();

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (a == 24'h000123)
            return 8'hA5;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5C;
    endfunction

    function automatic exp_t idle_e(input logic [7:0] d);
        exp_t e;
        e = '{kind: 2'd0, sel: 1'b1, sclk: 1'b0, oe: 4'h0, out: 4'h0, ready: 1'b0, data: d};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam logic [23:0] BASE = (g == 0) ? 24'h000000 : 24'hFFFFF0;

        assign bus[g].req   = req;
        assign bus[g].addr  = addr;
        assign bus[g].flush = flush;

        qspi_rom_fetch_ctrl #(
            .BASE_ADDR    (BASE),
            .READ_CMD     (CMD),
            .DUMMY_CYCLES (DUM)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g])
        );

        // Flash emulator: decodes the nibble stream and answers with its stored byte.
        logic [4:0]  e_nib  = '0;
        logic [7:0]  e_cmd  = '0;
        logic [23:0] e_addr = '0;
        logic        e_psel = 1'b1;
        int          e_ntx  = 0;
        logic [7:0]  e_byte;

        assign e_byte        = flash_byte(e_addr);
        assign bus[g].spi_in = (e_nib == 5'(8 + DUM)) ? e_byte[7:4] :
                               (e_nib == 5'(9 + DUM)) ? e_byte[3:0] : 4'h9;
        assign emu_cmd[g]    = e_cmd;
        assign emu_addr[g]   = e_addr;
        assign emu_ntx[g]    = e_ntx;

        always @(posedge clk) begin
            e_psel <= bus[g].spi_select;
            if (e_psel && !bus[g].spi_select)
                e_ntx <= e_ntx + 1;
            if (bus[g].spi_select)
                e_nib <= '0;
            else if (bus[g].spi_clk) begin
                if (e_nib < 5'd2)
                    e_cmd <= {e_cmd[3:0], bus[g].spi_out};
                else if (e_nib < 5'd8)
                    e_addr <= {e_addr[19:0], bus[g].spi_out};
                e_nib <= e_nib + 5'd1;
            end
        end

        // Expectation model: a fetch is a precomputed list of per-cycle pin values.
        exp_t        q[$];
        exp_t        cur = idle_e(8'h00);
        logic        m_valid = 1'b0;
        logic [11:0] m_tag = '0;
        logic [7:0]  m_byte = '0;
        logic [7:0]  m_last = '0;
        logic        m_flag = 1'b0;
        logic        pend = 1'b0;
        logic [11:0] p_tag = '0;
        logic [7:0]  p_byte = '0;

        task automatic m_reset();
            q.delete();
            cur     = idle_e(8'h00);
            m_valid = 1'b0;
            m_last  = 8'h00;
            m_flag  = 1'b0;
            pend    = 1'b0;
        endtask

        always @(posedge clk) begin
            if (!rst_n) begin
                m_reset();
            end else begin
                if (flush) begin
                    m_valid = 1'b0;
                    m_flag  = 1'b1;
                end
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    if (cur.kind == 2'd2 && pend) begin
                        if (!m_flag) begin
                            m_valid = 1'b1;
                            m_tag   = p_tag;
                            m_byte  = p_byte;
                        end
                        pend   = 1'b0;
                        m_last = cur.data;
                    end
                end else if (cur.kind == 2'd2) begin
                    cur = idle_e(m_last);
                end else if (req) begin
                    if (m_valid && m_tag == addr) begin
                        cur = '{kind: 2'd2, sel: 1'b1, sclk: 1'b0, oe: 4'h0, out: 4'h0,
                                ready: 1'b1, data: m_byte};
                        m_last = m_byte;
                    end else begin
                        logic [23:0] fa;
                        logic [23:0] sh;
                        exp_t        e;
                        fa = BASE + {12'h000, addr};
                        for (int k = 0; k < int'(T); k++) begin
                            for (int p = 0; p < 2; p++) begin
                                e = idle_e(m_last);
                                e.kind = 2'd1;
                                e.sel  = 1'b0;
                                e.sclk = (p == 1);
                                if (k < 8) begin
                                    e.oe = 4'hF;
                                    if (k == 0)
                                        e.out = CMD[7:4];
                                    else if (k == 1)
                                        e.out = CMD[3:0];
                                    else begin
                                        sh    = fa >> (4 * (7 - k));
                                        e.out = sh[3:0];
                                    end
                                end
                                q.push_back(e);
                            end
                        end
                        q.push_back('{kind: 2'd2, sel: 1'b1, sclk: 1'b0, oe: 4'h0, out: 4'h0,
                                      ready: 1'b1, data: flash_byte(fa)});
                        cur    = q.pop_front();
                        p_tag  = addr;
                        p_byte = flash_byte(fa);
                        pend   = 1'b1;
                        m_flag = flush;
                    end
                end else begin
                    cur = idle_e(m_last);
                end
            end
        end

        always @(negedge clk) begin
            logic [23:0] got_v;
            logic [23:0] exp_v;
            logic        exp_stall;
            if (!rst_n) begin
                m_reset();
                exp_stall = req;
            end else if (cur.kind == 2'd1)
                exp_stall = 1'b1;
            else if (cur.kind == 2'd2)
                exp_stall = 1'b0;
            else
                exp_stall = req & ~(m_valid & (m_tag == addr) & ~flush);
            got_v = {3'b000, bus[g].spi_select, bus[g].spi_clk, bus[g].spi_oe, bus[g].spi_out,
                     bus[g].ready, bus[g].data, bus[g].stall};
            exp_v = {3'b000, cur.sel, cur.sclk, cur.oe, cur.out, cur.ready, cur.data, exp_stall};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL pins[%0d] {sel,sclk,oe,out,ready,data,stall}: got %b_%b_%h_%h_%b_%h_%b expected %b_%b_%h_%h_%b_%h_%b at %0t",
                         g, got_v[20], got_v[19], got_v[18:15], got_v[14:11], got_v[10],
                         got_v[9:2], got_v[1], exp_v[20], exp_v[19], exp_v[18:15], exp_v[14:11],
                         exp_v[10], exp_v[9:2], exp_v[1], $time);
            end
        end
    end

    int lat, nst, lat2, nst2, tx0, gap;
    logic rnd_on;
    logic [11:0] pool [8] = '{12'h123, 12'h200, 12'h7FF, 12'h000, 12'hFFF, 12'h020, 12'h555, 12'h0AA};

    // Raise req with address a (called just after a clock edge) and wait for ready on instance 0.
    task automatic req_wait(input logic [11:0] a, output int l, output int s);
        req  = 1'b1;
        addr = a;
        l = 0;
        s = 0;
        @(negedge clk);
        while (!bus[0].ready && l < 100) begin
            s += int'(bus[0].stall);
            l++;
            @(negedge clk);
        end
        if (l >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: no ready within %0d cycles for addr %h", l, a);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        addr  = '0;
        flush = 1'b0;
        rnd_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_select", 32'(bus[0].spi_select), 32'd1);
        chk("reset_data", 32'(bus[1].data), 32'd0);
        rst_n = 1'b1;
        tick();

        // First miss of 0x123.
        req_wait(12'h123, lat, nst);
        chk("miss_latency", lat, 25);
        chk("miss_stall_cycles", nst, 25);
        chk("miss_data", 32'(bus[0].data), 32'hA5);
        chk("miss_cmd", 32'(emu_cmd[0]), 32'hEB);
        chk("miss_addr_base0", 32'(emu_addr[0]), 32'h000123);
        chk("miss_addr_wrapbase", 32'(emu_addr[1]), 32'h000113);
        tick();
        req = 1'b0;
        tick();

        // Hit of the same address.
        tx0 = emu_ntx[0];
        req_wait(12'h123, lat, nst);
        chk("hit_latency", lat, 1);
        chk("hit_stall_cycles", nst, 0);
        chk("hit_data", 32'(bus[0].data), 32'hA5);
        tick();
        req = 1'b0;
        chk("hit_no_bus", emu_ntx[0] - tx0, 0);
        tick();

        // Flush in IDLE, then refetch.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_wait(12'h123, lat, nst);
        chk("flush_idle_refetch", lat, 25);
        tick();
        req = 1'b0;
        tick();

        // Flush during DATA phase of a 0x200 fetch keeps it uncached.
        fork
            req_wait(12'h200, lat, nst);
            begin
                repeat (22) tick();
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
        join
        chk("flush_mid_latency", lat, 25);
        chk("flush_mid_data", 32'(bus[0].data), 32'(flash_byte(24'h000200)));
        tick();
        req = 1'b0;
        tick();
        req_wait(12'h200, lat, nst);
        chk("flush_mid_remiss", lat, 25);
        tick();
        req = 1'b0;
        tick();

        // Wrapping flash address on the high-base instance.
        req_wait(12'h020, lat, nst);
        chk("wrap_addr", 32'(emu_addr[1]), 32'h000010);
        chk("wrap_data", 32'(bus[1].data), 32'(flash_byte(24'h000010)));
        tick();
        req = 1'b0;
        tick();

        // Reset during the ADDR phase.
        req  = 1'b1;
        addr = 12'h7FF;
        repeat (8) tick();
        chk("pre_reset_select_low", 32'(bus[0].spi_select), 32'd0);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        chk("rst_mid_pins0", {28'd0, bus[0].spi_select, bus[0].spi_clk, bus[0].ready, |bus[0].spi_oe}, 32'b1000);
        chk("rst_mid_pins1", {28'd0, bus[1].spi_select, bus[1].spi_clk, bus[1].ready, |bus[1].spi_oe}, 32'b1000);
        tick();
        rst_n = 1'b1;
        tick();
        req_wait(12'h020, lat, nst);
        chk("post_reset_miss", lat, 25);
        tick();
        req = 1'b0;
        tick();

        // Request held high across two reads of 0x7FF.
        tx0 = emu_ntx[0];
        req_wait(12'h7FF, lat, nst);
        tick();
        req_wait(12'h7FF, lat2, nst2);
        chk("held_first_latency", lat, 25);
        chk("held_second_offset", lat + 1 + lat2, 27);
        chk("held_second_data", 32'(bus[0].data), 32'(flash_byte(24'h0007FF)));
        tick();
        req = 1'b0;
        chk("held_one_bus_txn", emu_ntx[0] - tx0, 1);
        tick();

        // Randomized traffic with random flush pulses.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [11:0] a;
                    if ($urandom_range(0, 3) == 0)
                        a = 12'($urandom);
                    else
                        a = pool[$urandom_range(0, 7)];
                    req_wait(a, lat, nst);
                    tick();
                    gap = int'($urandom_range(0, 3));
                    if (gap != 0) begin
                        req = 1'b0;
                        repeat (gap) tick();
                    end
                end
                req = 1'b0;
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    tick();
                    flush = ($urandom_range(0, 15) == 0);
                end
                flush = 1'b0;
            end
        join
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qspi_rom_fetch_ctrl.md
# qspi_rom_fetch_ctrl

Sequences single-byte cartridge ROM reads from the external QSPI flash (or its emulator) on behalf of the 6502 core. It shares the uio QSPI pins with the flash and stalls the CPU while a fetch is in flight. A one-entry byte cache returns repeat reads of the same address without a bus transaction. It sits between the CPU address/data path (A12 = ROM select) and uio_out[5:0] / uio_in[3:0].

## Interface
- BASE_ADDR, 24'h000000, flash byte offset of cartridge image; flash address = (BASE_ADDR + addr) mod 2^24
- READ_CMD, 8'hEB, command byte sent as two nibbles
- DUMMY_CYCLES, 2, dummy nibble periods between address and data (1..15)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  ROM read request; held by requester until ready
- addr  in  12  ROM byte offset, sampled when a fetch starts
- flush  in  1  invalidate cache entry
- ready  out  1  one-cycle pulse: data valid
- data  out  8  fetched byte; holds until next ready
- stall  out  1  CPU stall
- spi_clk  out  1  QSPI clock (drives uio_out[4])
- spi_select  out  1  chip select, active low (uio_out[5])
- spi_out  out  4  command/address nibble (uio_out[3:0])
- spi_oe  out  4  output enable for uio[3:0], all-ones or all-zeros
- spi_in  in  4  data nibble from flash (uio_in[3:0])

## Operation
- States: IDLE, CMD, ADDR, DUMMY, DATA, DONE.
- IDLE: req & hit (valid & tag==addr) -> DONE, no bus activity. req & miss -> CMD, latch addr. Otherwise stay.
- Nibble sequence per fetch: READ_CMD[7:4], READ_CMD[3:0]; 6 address nibbles MSB first; DUMMY_CYCLES dummy periods; 2 data nibbles, high first.
- spi_oe = 4'hF during CMD/ADDR, 4'h0 during DUMMY/DATA/IDLE/DONE. spi_out = 0 when not driving.
- DONE: ready=1, data updated, spi_select high. Cache tag/valid updated on miss completion unless flush was seen at any point during the fetch (sticky flag). Next state IDLE unconditionally; req ignored in DONE.
- flush in IDLE clears valid same edge; flush concurrent with a hit in IDLE: flush wins, treated as miss.
- Requester keeping req high after ready issues a new request evaluated in the following IDLE cycle (same address -> hit).
- stall = (req & ~hit & state==IDLE) | state in {CMD, ADDR, DUMMY, DATA}. Combinational.
- Reset (async, any state): state IDLE, spi_select=1, spi_clk=0, spi_oe=0, spi_out=0, ready=0, data=0, cache valid=0, flush flag=0.

## Timing
- Each nibble period = 2 clk: first cycle spi_clk=0 with spi_out stable, second spi_clk=1. spi_in sampled on the clk edge ending the spi_clk=1 cycle.
- Miss request seen in IDLE in cycle N: spi_select low from N+1; nibble k occupies N+1+2k, N+2+2k; total nibbles T=10+DUMMY_CYCLES; ready in cycle N+1+2T (N+25 at default), spi_select high that cycle.
- Hit in cycle N: ready in N+1, stall never asserted.
- Minimum request spacing: ready cycle + 1 IDLE cycle.
- spi_clk is registered; no glitches; low whenever spi_select is high.

## Test plan
- Miss, BASE_ADDR=0, addr=0x123, emulator byte 0xA5 -> spi_out nibbles E,B,0,0,0,1,2,3 with oe=F for 16 clk, 4 clk dummy with oe=0, ready in N+25 with data=0xA5, stall high N..N+24.
- Repeat addr=0x123 after ready -> ready at N+1, data=0xA5, spi_select stays high, stall low.
- flush asserted in IDLE, then addr=0x123 -> full 25-cycle fetch; flush pulsed mid-DATA of a fetch of 0x200 -> data returned, next 0x200 read still misses.
- BASE_ADDR=24'hFFFFF0, addr=0x020 -> address nibbles 0,0,0,0,1,0 (wrap).
- rst_n low during ADDR phase -> same instant spi_select=1, spi_clk=0, spi_oe=0, ready=0; after release, req for previously cached address misses.
- req held high across two accesses of 0x7FF -> first ready N+25, second ready N+27 (hit), no second bus transaction.
